// File: rtl/barrel_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Anything that depends on WIDTH lives in the modules, not here.
package barrel_shifter_pkg;

   typedef enum logic [1:0] {
      SH_LSR = 2'b00,
      SH_LSL = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_mode_e;

   // Reverses the low w bits of d; bits at w and above come back as zero.
   function automatic logic [63:0] bitrev(input logic [63:0] d, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) r[6'(i)] = d[6'(w - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/barrel_shifter_pipe_shift_level.sv
// One log2 mux level of the right-shift core: shifts by DIST when enabled.
// ROR wraps the low bits around; the other modes fill and record lost bits.
module shift_level
   import barrel_shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_en,
   input  shift_mode_e      i_mode,
   input  logic             i_fill,
   input  logic             i_lost,
   output logic [WIDTH-1:0] o_data,
   output logic             o_lost
);

   always_comb begin
      o_data = i_data;
      o_lost = i_lost;
      if (i_en) begin
         if (i_mode == SH_ROR) begin
            o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
         end else begin
            o_data = {{DIST{i_fill}}, i_data[WIDTH-1:DIST]};
            o_lost = i_lost | (|i_data[DIST-1:0]);
         end
      end
   end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter with elastic stages and a sticky lost flag.
// LSL runs through the right-shift core with the operand bit-reversed in and out.
module barrel_shifter_pipe
   import barrel_shifter_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int STAGES  = 2,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_lost
);

   logic [STAGES-1:0]  r_valid;
   logic [STAGES-1:0]  r_lost;
   logic               r_fill  [STAGES];
   logic [WIDTH-1:0]   r_data  [STAGES];
   logic [SHAMT_W-1:0] r_shamt [STAGES];
   shift_mode_e        r_mode  [STAGES];

   logic [STAGES-1:0]  w_in_valid;
   logic [STAGES-1:0]  w_in_fill;
   logic [STAGES-1:0]  w_in_lost;
   logic [STAGES-1:0]  w_next_lost;
   logic [STAGES-1:0]  w_load;
   logic [WIDTH-1:0]   w_in_data   [STAGES];
   logic [WIDTH-1:0]   w_next_data [STAGES];
   logic [SHAMT_W-1:0] w_in_shamt  [STAGES];
   shift_mode_e        w_in_mode   [STAGES];
   logic [WIDTH-1:0]   w_pre_data;

   assign w_pre_data = (in_mode == SH_LSL) ? WIDTH'(bitrev(64'(in_data), WIDTH)) : in_data;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_src
         assign w_in_valid[s] = in_valid;
         assign w_in_data[s]  = w_pre_data;
         assign w_in_shamt[s] = in_shamt;
         assign w_in_mode[s]  = shift_mode_e'(in_mode);
         assign w_in_fill[s]  = (in_mode == SH_ASR) & in_data[WIDTH-1];
         assign w_in_lost[s]  = 1'b0;
      end else begin : g_src
         assign w_in_valid[s] = r_valid[s-1];
         assign w_in_data[s]  = r_data[s-1];
         assign w_in_shamt[s] = r_shamt[s-1];
         assign w_in_mode[s]  = r_mode[s-1];
         assign w_in_fill[s]  = r_fill[s-1];
         assign w_in_lost[s]  = r_lost[s-1];
      end

      // Every level is walked here; only those mapped to this stage do any work.
      for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
         logic [WIDTH-1:0] w_d_in;
         logic [WIDTH-1:0] w_d_out;
         logic             w_l_in;
         logic             w_l_out;

         if (k == 0) begin : g_head
            assign w_d_in = w_in_data[s];
            assign w_l_in = w_in_lost[s];
         end else begin : g_link
            assign w_d_in = g_lvl[k-1].w_d_out;
            assign w_l_in = g_lvl[k-1].w_l_out;
         end

         if ((k * STAGES) / SHAMT_W == s) begin : g_active
            shift_level #(
               .WIDTH (WIDTH),
               .DIST  (1 << k)
            ) u_level (
               .i_data (w_d_in),
               .i_en   (w_in_shamt[s][k]),
               .i_mode (w_in_mode[s]),
               .i_fill (w_in_fill[s]),
               .i_lost (w_l_in),
               .o_data (w_d_out),
               .o_lost (w_l_out)
            );
         end else begin : g_bypass
            assign w_d_out = w_d_in;
            assign w_l_out = w_l_in;
         end
      end

      if (s == STAGES - 1) begin : g_post
         assign w_next_data[s] = (w_in_mode[s] == SH_LSL)
                               ? WIDTH'(bitrev(64'(g_lvl[SHAMT_W-1].w_d_out), WIDTH))
                               : g_lvl[SHAMT_W-1].w_d_out;
      end else begin : g_post
         assign w_next_data[s] = g_lvl[SHAMT_W-1].w_d_out;
      end
      assign w_next_lost[s] = g_lvl[SHAMT_W-1].w_l_out;

      // A stage can take new data if any stage from here to the output has a hole.
      assign w_load[s] = out_ready | ~(&r_valid[STAGES-1:s]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_lost  <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_fill[s]  <= 1'b0;
            r_data[s]  <= '0;
            r_shamt[s] <= '0;
            r_mode[s]  <= SH_LSR;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (w_load[s]) begin
               r_valid[s] <= w_in_valid[s];
               if (w_in_valid[s]) begin
                  r_data[s]  <= w_next_data[s];
                  r_shamt[s] <= w_in_shamt[s];
                  r_mode[s]  <= w_in_mode[s];
                  r_fill[s]  <= w_in_fill[s];
                  r_lost[s]  <= w_next_lost[s];
               end
            end
         end
      end
   end

   assign in_ready  = w_load[0];
   assign out_valid = r_valid[STAGES-1];
   assign out_data  = r_data[STAGES-1];
   assign out_lost  = r_lost[STAGES-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: directed cases on an 8-bit/2-stage instance plus
// random traffic on 32-bit instances, all scored against an arithmetic model.
module tb_barrel_shifter_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        d_valid = 1'b0;
   logic        d_ready = 1'b0;
   logic [31:0] d_data = '0;
   logic [4:0]  d_shamt = '0;
   logic [1:0]  d_mode = '0;
   logic [31:0] rnd;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Plain arithmetic reference: result and lost flag for a w-bit operand d.
   function automatic void ref_shift(input logic [63:0] d, input int n, input int m, input int w,
                                     output logic [63:0] r, output logic l);
      logic [63:0] mask;
      logic [63:0] low;
      mask = (64'd1 << w) - 64'd1;
      low  = (64'd1 << n) - 64'd1;
      case (m)
         0: begin r = d >> n; l = (d & low) != 0; end
         1: begin r = (d << n) & mask; l = (n != 0) && ((d >> (w - n)) != 0); end
         2: begin
            r = d >> n;
            if (d[w-1]) r = r | (mask & ~(mask >> n));
            l = (d & low) != 0;
         end
         default: begin r = ((d >> n) | (d << (w - n))) & mask; l = 1'b0; end
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W  = (g == 0) ? 8 : 32;
      localparam int S  = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
      localparam int SW = $clog2(W);

      logic         in_ready;
      logic         out_valid;
      logic         out_lost;
      logic [W-1:0] out_data;
      logic [W:0]   exp_q[$];

      barrel_shifter_pipe #(
         .WIDTH  (W),
         .STAGES (S)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (d_valid),
         .in_ready  (in_ready),
         .in_data   (d_data[W-1:0]),
         .in_shamt  (d_shamt[SW-1:0]),
         .in_mode   (d_mode),
         .out_valid (out_valid),
         .out_ready (d_ready),
         .out_data  (out_data),
         .out_lost  (out_lost)
      );

      always @(negedge clk) begin : mon
         logic [63:0] r;
         logic        l;
         logic [W:0]  e;
         if (!rst_n) begin
            exp_q.delete();
         end else begin
            if (out_valid && d_ready) begin
               if (exp_q.size() == 0) begin
                  check_eq($sformatf("sb_extra_%0d", g), 65'(out_valid), 65'(0));
               end else begin
                  e = exp_q.pop_front();
                  check_eq($sformatf("sb_result_%0d", g), 65'({out_lost, out_data}), 65'(e));
               end
            end
            if (d_valid && in_ready) begin
               ref_shift(64'(d_data[W-1:0]), int'(d_shamt[SW-1:0]), int'(d_mode), W, r, l);
               exp_q.push_back({l, r[W-1:0]});
            end
         end
      end
   end

   // Called at posedge+1 with an empty pipe; returns at posedge+1.
   task automatic do_op(input logic [31:0] dat, input int n, input int m,
                        input logic [7:0] exp_d, input logic exp_l, input string tag);
      d_data  = dat;
      d_shamt = 5'(n);
      d_mode  = 2'(m);
      d_valid = 1'b1;
      d_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, "_rdy"}, 65'(g_dut[0].in_ready), 65'(1));
      @(posedge clk); #1;
      d_valid = 1'b0;
      @(negedge clk);
      check_eq({tag, "_early"}, 65'(g_dut[0].out_valid), 65'(0));
      @(negedge clk);
      check_eq({tag, "_valid"}, 65'(g_dut[0].out_valid), 65'(1));
      check_eq({tag, "_data"}, 65'(g_dut[0].out_data), 65'(exp_d));
      check_eq({tag, "_lost"}, 65'(g_dut[0].out_lost), 65'(exp_l));
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst_valid", 65'(g_dut[0].out_valid), 65'(0));
      check_eq("rst_data", 65'(g_dut[0].out_data), 65'(0));
      check_eq("rst_lost", 65'(g_dut[0].out_lost), 65'(0));
      check_eq("rst_valid32", 65'(g_dut[3].out_valid), 65'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", 65'(g_dut[0].in_ready), 65'(1));
      @(posedge clk); #1;

      do_op(32'hB4, 3, 0, 8'h16, 1'b1, "lsr");
      do_op(32'hB4, 2, 2, 8'hED, 1'b0, "asr");
      do_op(32'hB4, 1, 1, 8'h68, 1'b1, "lsl");
      do_op(32'hB4, 4, 3, 8'h4B, 1'b0, "ror");
      for (int m = 0; m < 4; m++) begin
         rnd = $urandom;
         do_op(rnd, 0, m, rnd[7:0], 1'b0, "n0");
      end

      // Backpressure: two ops fill the pipe, the third must wait.
      d_ready = 1'b0;
      d_valid = 1'b1;
      d_data  = 32'hB4;
      d_shamt = 5'd3;
      d_mode  = 2'd0;
      @(negedge clk);
      check_eq("bp_rdy0", 65'(g_dut[0].in_ready), 65'(1));
      @(posedge clk); #1;
      d_shamt = 5'd2;
      d_mode  = 2'd2;
      @(negedge clk);
      check_eq("bp_rdy1", 65'(g_dut[0].in_ready), 65'(1));
      @(posedge clk); #1;
      d_shamt = 5'd1;
      d_mode  = 2'd1;
      @(negedge clk);
      check_eq("bp_full", 65'(g_dut[0].in_ready), 65'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_eq("bp_hold", 65'({g_dut[0].out_valid, g_dut[0].out_lost, g_dut[0].out_data}),
                  65'({1'b1, 1'b1, 8'h16}));
         check_eq("bp_stall", 65'(g_dut[0].in_ready), 65'(0));
      end
      @(posedge clk); #1;
      d_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_out0", 65'({g_dut[0].out_valid, g_dut[0].out_lost, g_dut[0].out_data}),
               65'({1'b1, 1'b1, 8'h16}));
      check_eq("bp_pass", 65'(g_dut[0].in_ready), 65'(1));
      @(posedge clk); #1;
      d_valid = 1'b0;
      @(negedge clk);
      check_eq("bp_out1", 65'({g_dut[0].out_valid, g_dut[0].out_lost, g_dut[0].out_data}),
               65'({1'b1, 1'b0, 8'hED}));
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("bp_out2", 65'({g_dut[0].out_valid, g_dut[0].out_lost, g_dut[0].out_data}),
               65'({1'b1, 1'b1, 8'h68}));
      @(posedge clk); #1;

      // Full-rate streaming.
      for (int i = 0; i < 100; i++) begin
         d_valid = 1'b1;
         d_ready = 1'b1;
         d_data  = $urandom;
         d_shamt = 5'($urandom_range(0, 31));
         d_mode  = 2'($urandom_range(0, 3));
         @(negedge clk);
         check_eq("thru_rdy", 65'(g_dut[0].in_ready), 65'(1));
         if (i >= 2) check_eq("thru_valid", 65'(g_dut[0].out_valid), 65'(1));
         @(posedge clk); #1;
      end

      // Random valid/ready on both sides.
      for (int i = 0; i < 400; i++) begin
         d_valid = 1'($urandom_range(0, 1));
         d_ready = ($urandom_range(0, 3) != 0);
         d_data  = $urandom;
         d_shamt = 5'($urandom_range(0, 31));
         d_mode  = 2'($urandom_range(0, 3));
         @(negedge clk);
         @(posedge clk); #1;
      end
      d_valid = 1'b0;
      d_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      check_eq("drain_0", 65'(g_dut[0].exp_q.size()), 65'(0));
      check_eq("drain_1", 65'(g_dut[1].exp_q.size()), 65'(0));
      check_eq("drain_2", 65'(g_dut[2].exp_q.size()), 65'(0));
      check_eq("drain_3", 65'(g_dut[3].exp_q.size()), 65'(0));

      // Reset with two ops in flight.
      d_ready = 1'b0;
      d_valid = 1'b1;
      repeat (2) begin
         d_data  = $urandom;
         d_shamt = 5'($urandom_range(0, 31));
         d_mode  = 2'($urandom_range(0, 3));
         @(negedge clk);
         @(posedge clk); #1;
      end
      d_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_valid", 65'(g_dut[0].out_valid), 65'(1));
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_0", 65'(g_dut[0].out_valid), 65'(0));
      check_eq("async_rst_3", 65'(g_dut[3].out_valid), 65'(0));
      @(negedge clk);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      d_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("no_stale", 65'(g_dut[0].out_valid), 65'(0));
         check_eq("no_stale32", 65'(g_dut[3].out_valid), 65'(0));
         @(posedge clk); #1;
      end
      do_op(32'hB4, 3, 0, 8'h16, 1'b1, "post_rst");
      repeat (8) begin
         @(negedge clk);
         @(posedge clk); #1;
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
